// File: rtl/arith_pkg.sv
// Shared constants and state encoding for the sequential arithmetic unit.
package arith_pkg;

  localparam int unsigned DVD_W  = 8;
  localparam int unsigned DVS_W  = 4;
  localparam int unsigned ITER_N = 8;
  localparam int unsigned CNT_W  = $clog2(ITER_N);

  typedef enum logic [2:0] {
    StIdle,
    StPrep,
    StDiv,
    StFix,
    StDone
  } div_state_e;

endpackage

// File: rtl/seq_divider_ctrl.sv
// Divider controller: sequences PREP, DIV iterations and FIX, and owns the iteration counter.
module seq_divider_ctrl
  import arith_pkg::*;
(
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic             zero_dvs,
  input  logic             last_iter,
  output logic             load,
  output logic             prep,
  output logic             shift_sub,
  output logic             fix,
  output logic             ready,
  output logic [CNT_W-1:0] iter
);

  div_state_e       state_q, state_d;
  logic [CNT_W-1:0] iter_q, iter_d;

  assign iter = iter_q;

  // State and iteration counter registers with synchronous active-low reset.
  always_ff @(posedge clk) begin
    if (!reset) begin
      state_q <= StIdle;
      iter_q  <= '0;
    end else begin
      state_q <= state_d;
      iter_q  <= iter_d;
    end
  end

  // Next-state decode and datapath strobes.
  always_comb begin
    state_d   = state_q;
    iter_d    = iter_q;
    load      = 1'b0;
    prep      = 1'b0;
    shift_sub = 1'b0;
    fix       = 1'b0;
    ready     = 1'b0;
    case (state_q)
      StIdle: begin
        if (start) begin
          load    = 1'b1;
          state_d = StPrep;
        end
      end
      StPrep: begin
        prep    = 1'b1;
        iter_d  = '0;
        state_d = zero_dvs ? StDone : StDiv;
      end
      StDiv: begin
        shift_sub = 1'b1;
        iter_d    = iter_q + 1'b1;
        if (last_iter) begin
          state_d = StFix;
        end
      end
      StFix: begin
        fix     = 1'b1;
        state_d = StDone;
      end
      StDone: begin
        ready = 1'b1;
        // A new start leaves DONE immediately, so ready drops on this edge.
        if (start) begin
          load    = 1'b1;
          state_d = StPrep;
        end
      end
      default: state_d = StIdle;
    endcase
  end

endmodule

// File: rtl/seq_divider.sv
// Sequential restoring divider datapath: 8-bit dividend / 4-bit divisor, signed or unsigned.
module seq_divider
  import arith_pkg::*;
(
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic             sign,
  input  logic [DVD_W-1:0] dividend,
  input  logic [DVS_W-1:0] divisor,
  output logic [DVD_W-1:0] quotient,
  output logic [DVS_W-1:0] remainder,
  output logic             ready,
  output logic             div_zero,
  output logic             overflow
);

  logic             load, prep, shift_sub, fix;
  logic             zero_dvs, last_iter;
  logic [CNT_W-1:0] iter;

  // Operands latched on start; the working registers only change while busy.
  logic             sign_q;
  logic [DVD_W-1:0] dvd_in_q;
  logic [DVS_W-1:0] dvs_in_q;
  logic [DVD_W-1:0] work_q;
  logic [DVS_W-1:0] prem_q;
  logic [DVS_W-1:0] dvs_mag_q;
  logic             q_neg_q, r_neg_q;
  logic [DVD_W-1:0] quotient_q;
  logic [DVS_W-1:0] remainder_q;
  logic             div_zero_q, overflow_q;

  logic             dvd_neg, dvs_neg, ovf_case;
  logic [DVD_W-1:0] dvd_mag;
  logic [DVS_W-1:0] dvs_mag;
  logic [DVS_W:0]   shifted;
  logic [DVS_W+1:0] trial;
  logic             trial_ok;
  logic [DVS_W-1:0] prem_next;
  logic [DVD_W-1:0] quo_fix;
  logic [DVS_W-1:0] rem_fix;

  seq_divider_ctrl u_ctrl (
    .clk       (clk),
    .reset     (reset),
    .start     (start),
    .zero_dvs  (zero_dvs),
    .last_iter (last_iter),
    .load      (load),
    .prep      (prep),
    .shift_sub (shift_sub),
    .fix       (fix),
    .ready     (ready),
    .iter      (iter)
  );

  assign zero_dvs  = (dvs_in_q == '0);
  assign last_iter = (iter == CNT_W'(ITER_N - 1));

  assign quotient  = quotient_q;
  assign remainder = remainder_q;
  assign div_zero  = div_zero_q;
  assign overflow  = overflow_q;

  // Operand magnitudes, one restoring step and the final sign correction.
  always_comb begin
    dvd_neg  = sign_q & dvd_in_q[DVD_W-1];
    dvs_neg  = sign_q & dvs_in_q[DVS_W-1];
    // -128 and -8 still fit as unsigned magnitudes in 8 and 4 bits.
    dvd_mag  = dvd_neg ? (~dvd_in_q + 1'b1) : dvd_in_q;
    dvs_mag  = dvs_neg ? (~dvs_in_q + 1'b1) : dvs_in_q;
    ovf_case = sign_q & (dvd_in_q == 8'h80) & (dvs_in_q == 4'hF);

    shifted  = {prem_q, work_q[DVD_W-1]};
    // 5-bit subtract with its borrow kept in the extra top bit.
    trial    = {1'b0, shifted} - {2'b00, dvs_mag_q};
    trial_ok = ~trial[DVS_W+1];
    // Either way the kept value is below the divisor, so it fits 4 bits.
    prem_next = trial_ok ? trial[DVS_W-1:0] : shifted[DVS_W-1:0];

    quo_fix  = q_neg_q ? (~work_q + 1'b1) : work_q;
    rem_fix  = r_neg_q ? (~prem_q + 1'b1) : prem_q;
  end

  // Operand latch, iteration datapath and result registers.
  always_ff @(posedge clk) begin
    if (!reset) begin
      sign_q      <= 1'b0;
      dvd_in_q    <= '0;
      dvs_in_q    <= '0;
      work_q      <= '0;
      prem_q      <= '0;
      dvs_mag_q   <= '0;
      q_neg_q     <= 1'b0;
      r_neg_q     <= 1'b0;
      quotient_q  <= '0;
      remainder_q <= '0;
      div_zero_q  <= 1'b0;
      overflow_q  <= 1'b0;
    end else begin
      if (load) begin
        sign_q     <= sign;
        dvd_in_q   <= dividend;
        dvs_in_q   <= divisor;
        div_zero_q <= 1'b0;
        overflow_q <= 1'b0;
      end
      if (prep) begin
        if (zero_dvs) begin
          quotient_q  <= '1;
          remainder_q <= dvd_in_q[DVS_W-1:0];
          div_zero_q  <= 1'b1;
        end else begin
          work_q    <= dvd_mag;
          dvs_mag_q <= dvs_mag;
          prem_q    <= '0;
          q_neg_q   <= dvd_neg ^ dvs_neg;
          r_neg_q   <= dvd_neg;
        end
      end
      if (shift_sub) begin
        work_q <= {work_q[DVD_W-2:0], trial_ok};
        prem_q <= prem_next;
      end
      if (fix) begin
        if (ovf_case) begin
          quotient_q  <= 8'h80;
          remainder_q <= '0;
          overflow_q  <= 1'b1;
        end else begin
          quotient_q  <= quo_fix;
          remainder_q <= rem_fix;
        end
      end
    end
  end

endmodule

// File: tb/tb_seq_divider.sv
// Self-checking bench for seq_divider using a queue-based scoreboard.
module tb_seq_divider;

  logic       clk = 1'b0;
  logic       reset;
  logic       start;
  logic       sign;
  logic [7:0] dividend;
  logic [3:0] divisor;
  logic [7:0] quotient;
  logic [3:0] remainder;
  logic       ready;
  logic       div_zero;
  logic       overflow;

  typedef struct {
    logic [7:0]  q;
    logic [3:0]  r;
    logic        dz;
    logic        ov;
    int unsigned lat;
  } exp_t;

  exp_t sb[$];
  int   n_checks = 0;
  int   n_errors = 0;

  seq_divider dut (
    .clk       (clk),
    .reset     (reset),
    .start     (start),
    .sign      (sign),
    .dividend  (dividend),
    .divisor   (divisor),
    .quotient  (quotient),
    .remainder (remainder),
    .ready     (ready),
    .div_zero  (div_zero),
    .overflow  (overflow)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Reference: integer division truncating toward zero, remainder follows dividend.
  function automatic exp_t model(input logic s, input logic [7:0] a, input logic [3:0] b);
    exp_t e;
    int   ai, bi, qi, ri;
    e.dz  = 1'b0;
    e.ov  = 1'b0;
    e.lat = 10;
    if (b == 4'd0) begin
      e.q   = 8'hFF;
      e.r   = a[3:0];
      e.dz  = 1'b1;
      e.lat = 1;
    end else begin
      if (s) begin
        ai = {{24{a[7]}}, a};
        bi = {{28{b[3]}}, b};
      end else begin
        ai = {24'd0, a};
        bi = {28'd0, b};
      end
      qi   = ai / bi;
      ri   = ai % bi;
      e.q  = qi[7:0];
      e.r  = ri[3:0];
      e.ov = s && (a == 8'h80) && (b == 4'hF);
    end
    return e;
  endfunction

  task automatic wait_ready(output int cyc);
    cyc = 0;
    while (ready !== 1'b1 && cyc < 40) begin
      @(posedge clk);
      #1;
      cyc++;
    end
  endtask

  task automatic compare_result(input string tag, input int cyc);
    exp_t e;
    check({tag, "_sb_size"}, 32'(sb.size()), 32'd1);
    if (sb.size() > 0) begin
      e = sb.pop_front();
      check({tag, "_latency"}, 32'(cyc), 32'(e.lat));
      check({tag, "_quotient"}, 32'(quotient), 32'(e.q));
      check({tag, "_remainder"}, 32'(remainder), 32'(e.r));
      check({tag, "_div_zero"}, 32'(div_zero), 32'(e.dz));
      check({tag, "_overflow"}, 32'(overflow), 32'(e.ov));
    end
  endtask

  task automatic run_op(input string tag, input logic s, input logic [7:0] a,
                        input logic [3:0] b);
    int cyc;
    @(negedge clk);
    sign     = s;
    dividend = a;
    divisor  = b;
    start    = 1'b1;
    sb.push_back(model(s, a, b));
    @(posedge clk);
    #1;
    start = 1'b0;
    // Scramble inputs while busy; the result must follow the latched operands.
    sign     = 1'($urandom);
    dividend = 8'($urandom);
    divisor  = 4'($urandom);
    check({tag, "_ready_drop"}, 32'(ready), 32'd0);
    wait_ready(cyc);
    compare_result(tag, cyc);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: observed timeout expected completion");
    $fatal(1);
  end

  initial begin
    int cyc;
    reset    = 1'b0;
    start    = 1'b0;
    sign     = 1'b0;
    dividend = '0;
    divisor  = '0;
    repeat (3) @(posedge clk);
    #1;
    check("rst_quotient", 32'(quotient), 32'd0);
    check("rst_remainder", 32'(remainder), 32'd0);
    check("rst_ready", 32'(ready), 32'd0);
    check("rst_div_zero", 32'(div_zero), 32'd0);
    check("rst_overflow", 32'(overflow), 32'd0);
    @(negedge clk);
    reset = 1'b1;

    run_op("u100_7", 1'b0, 8'd100, 4'd7);
    run_op("s_m100_7", 1'b1, 8'h9C, 4'h7);
    run_op("s_7_m3", 1'b1, 8'h07, 4'hD);
    run_op("dz_200", 1'b0, 8'd200, 4'd0);
    run_op("s_ovf", 1'b1, 8'h80, 4'hF);
    run_op("u_80_f", 1'b0, 8'h80, 4'hF);

    // Result must hold while idle in DONE.
    repeat (3) begin
      @(posedge clk);
      #1;
      check("hold_ready", 32'(ready), 32'd1);
      check("hold_quotient", 32'(quotient), 32'd8);
      check("hold_remainder", 32'(remainder), 32'd8);
    end

    // start held high; operands change during DIV to a second operation.
    @(negedge clk);
    sign     = 1'b1;
    dividend = 8'h9C;
    divisor  = 4'h7;
    start    = 1'b1;
    sb.push_back(model(1'b1, 8'h9C, 4'h7));
    @(posedge clk);
    #1;
    check("held_ready_drop", 32'(ready), 32'd0);
    repeat (3) @(posedge clk);
    #1;
    sign     = 1'b0;
    dividend = 8'd255;
    divisor  = 4'd15;
    wait_ready(cyc);
    cyc = cyc + 3;
    compare_result("held_a", cyc);
    sb.push_back(model(1'b0, 8'd255, 4'd15));
    @(posedge clk);
    #1;
    check("held_one_cycle", 32'(ready), 32'd0);
    start = 1'b0;
    wait_ready(cyc);
    compare_result("held_b", cyc);

    // Reset in the middle of the iterations.
    @(negedge clk);
    sign     = 1'b0;
    dividend = 8'd100;
    divisor  = 4'd7;
    start    = 1'b1;
    @(posedge clk);
    #1;
    start = 1'b0;
    repeat (5) @(posedge clk);
    @(negedge clk);
    reset = 1'b0;
    @(posedge clk);
    #1;
    check("midrst_quotient", 32'(quotient), 32'd0);
    check("midrst_remainder", 32'(remainder), 32'd0);
    check("midrst_ready", 32'(ready), 32'd0);
    check("midrst_div_zero", 32'(div_zero), 32'd0);
    check("midrst_overflow", 32'(overflow), 32'd0);
    @(negedge clk);
    reset = 1'b1;
    repeat (12) @(posedge clk);
    #1;
    check("midrst_idle", 32'(ready), 32'd0);
    run_op("u255_15", 1'b0, 8'd255, 4'd15);

    for (int i = 0; i < 24; i++) begin
      run_op("rand", 1'($urandom), 8'($urandom), 4'($urandom_range(0, 15)));
    end

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
